// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: accepts one access, waits LATENCY
// cycles while stalling the pipeline, then pulses done with load data or a misalign flag.
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  size,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        done,
   output logic        misalign
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] LAST_WAIT = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Size codes: [1:0]=00 byte, 01 half, anything else is treated as a word.
   function automatic logic isMisaligned(input logic [2:0] sz, input logic [1:0] lane);
      case (sz[1:0])
         2'b00:   return 1'b0;
         2'b01:   return lane[0];
         default: return (lane != 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] laneMask(input logic [2:0] sz, input logic [1:0] lane);
      case (sz[1:0])
         2'b00:   return 4'b0001 << lane;
         2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Replicate the low lanes so the byte mask alone decides where data lands.
   function automatic logic [31:0] storeWord(input logic [2:0] sz, input logic [31:0] d);
      case (sz[1:0])
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] loadExtract(input logic [31:0] word, input logic [2:0] sz,
                                               input logic [1:0] lane);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (sz[1:0])
         2'b00:   return sz[2] ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
         2'b01:   return sz[2] ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: return word;
      endcase
   endfunction

   logic [31:0]   mem [DEPTH];
   state_t        state_r;
   logic [3:0]    waitCnt_r;
   logic [AW+1:0] addrLat_r;
   logic          weLat_r;
   logic [31:0]   wdataLat_r;
   logic [2:0]    sizeLat_r;
   logic [31:0]   rdata_r;
   logic          done_r;
   logic          misalign_r;

   logic [AW+1:0] curAddr_s;
   logic          curWe_s;
   logic [31:0]   curWdata_s;
   logic [2:0]    curSize_s;
   logic [AW-1:0] curIdx_s;
   logic [1:0]    curLane_s;
   logic          curMis_s;
   logic          respGo_s;
   logic [3:0]    curMask_s;
   logic [31:0]   curStore_s;
   logic [31:0]   loadData_s;
   logic          unusedAddr_s;

   assign unusedAddr_s = ^addr[31:AW+2];

   // Select live inputs on the accepting cycle (LATENCY=0 path), latched copies otherwise.
   always_comb begin
      curAddr_s  = addrLat_r;
      curWe_s    = weLat_r;
      curWdata_s = wdataLat_r;
      curSize_s  = sizeLat_r;
      if (state_r == IDLE) begin
         curAddr_s  = addr[AW+1:0];
         curWe_s    = we;
         curWdata_s = wdata;
         curSize_s  = size;
      end else begin
         curAddr_s  = addrLat_r;
      end
   end

   assign curIdx_s   = curAddr_s[AW+1:2];
   assign curLane_s  = curAddr_s[1:0];
   assign curMis_s   = isMisaligned(curSize_s, curLane_s);
   assign curMask_s  = laneMask(curSize_s, curLane_s);
   assign curStore_s = storeWord(curSize_s, curWdata_s);
   assign loadData_s = loadExtract(mem[curIdx_s], curSize_s, curLane_s);

   // Asserted on the cycle whose closing edge enters RESP.
   always_comb begin
      respGo_s = 1'b0;
      if (state_r == IDLE) begin
         respGo_s = req && (LATENCY == 0);
      end else if (state_r == WAIT) begin
         respGo_s = (waitCnt_r == LAST_WAIT);
      end else begin
         respGo_s = 1'b0;
      end
   end

   assign stall    = (state_r == WAIT) || ((state_r == IDLE) && req);
   assign rdata    = rdata_r;
   assign done     = done_r;
   assign misalign = misalign_r;

   // Control FSM with registered response outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= IDLE;
         waitCnt_r  <= 4'd0;
         addrLat_r  <= '0;
         weLat_r    <= 1'b0;
         wdataLat_r <= 32'd0;
         sizeLat_r  <= 3'd0;
         rdata_r    <= 32'd0;
         done_r     <= 1'b0;
         misalign_r <= 1'b0;
      end else begin
         rdata_r    <= 32'd0;
         done_r     <= 1'b0;
         misalign_r <= 1'b0;
         if (respGo_s) begin
            done_r     <= 1'b1;
            misalign_r <= curMis_s;
            rdata_r    <= (curMis_s || curWe_s) ? 32'd0 : loadData_s;
         end
         case (state_r)
            IDLE: begin
               if (req) begin
                  addrLat_r  <= addr[AW+1:0];
                  weLat_r    <= we;
                  wdataLat_r <= wdata;
                  sizeLat_r  <= size;
                  waitCnt_r  <= 4'd0;
                  state_r    <= (LATENCY == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (respGo_s) begin
                  waitCnt_r <= 4'd0;
                  state_r   <= RESP;
               end else begin
                  waitCnt_r <= waitCnt_r + 4'd1;
               end
            end
            RESP:    state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

   // Data store: never cleared; a store commits only on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (reset && respGo_s && curWe_s && !curMis_s) begin
         for (int i = 0; i < 4; i++) begin
            if (curMask_s[i]) begin
               mem[curIdx_s][i*8 +: 8] <= curStore_s[i*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-array memory model;
// a second LATENCY=0 instance covers back-to-back responses.
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   typedef struct packed {
      logic        isStore;
      logic        mis;
      logic [31:0] data;
   } exp_t;

   logic        clk, reset;
   logic        req, we;
   logic [31:0] addr, wdata, rdata;
   logic [2:0]  size;
   logic        stall, done, misalign;

   logic        req0, we0;
   logic [31:0] addr0, wdata0, rdata0;
   logic [2:0]  size0;
   logic        stall0, done0, misalign0;

   int   checks = 0;
   int   errors = 0;
   logic monOn  = 1'b0;
   exp_t expQ[$];
   logic [7:0] refMem [DEPTH*4];

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .size(size), .rdata(rdata), .stall(stall), .done(done), .misalign(misalign));

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
      .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
      .size(size0), .rdata(rdata0), .stall(stall0), .done(done0), .misalign(misalign0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // Reference: byte-addressed memory, wrap modulo DEPTH*4, access width from funct3.
   function automatic exp_t refAccess(input logic w, input logic [31:0] a, input logic [31:0] d,
                                      input logic [2:0] s);
      exp_t e;
      int n, base;
      logic [31:0] v;
      n = (s == 3'd0 || s == 3'd4) ? 1 : ((s == 3'd1 || s == 3'd5) ? 2 : 4);
      base = int'(a % 32'(DEPTH*4));
      e.isStore = w;
      e.mis = (int'(a[1:0]) % n) != 0;
      v = 32'd0;
      if (!e.mis) begin
         for (int k = 0; k < n; k++) begin
            if (w) refMem[base+k] = d[8*k +: 8];
            else   v[8*k +: 8] = refMem[base+k];
         end
         if (!w && s == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
         if (!w && s == 3'd1 && v[15]) v = v | 32'hFFFF0000;
      end
      e.data = v;
      return e;
   endfunction

   // Monitor: pop on every done, otherwise outputs must be quiet.
   always @(negedge clk) begin
      if (monOn) begin
         if (done) begin
            if (expQ.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
               if (!e.isStore) chk("rdata", rdata, e.data);
            end
         end else begin
            chk("idle_quiet", {rdata[31:1], rdata[0] | misalign}, 32'd0);
         end
      end
   end

   // Issue one access at posedge+1; returns at posedge+1 after the response.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] s, input logic scramble);
      int cyc, stallCnt;
      logic seen;
      expQ.push_back(refAccess(w, a, d, s));
      req = 1'b1; we = w; addr = a; wdata = d; size = s;
      cyc = 0; stallCnt = 0; seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         if (stall) stallCnt++;
         if (done) begin
            seen = 1'b1;
         end else begin
            cyc++;
            if (cyc == 1 && scramble) begin
               @(posedge clk); #1;
               req = 1'($urandom); we = 1'($urandom); addr = $urandom;
               wdata = $urandom; size = 3'($urandom);
            end
         end
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
      chk("latency", 32'(cyc), 32'(LAT + 1));
      chk("stall_cycles", 32'(stallCnt), 32'(LAT + 1));
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   initial begin
      reset = 1'b0; req = 1'b1; we = 1'b0; addr = 32'd0; wdata = 32'd0; size = 3'd2;
      req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0; size0 = 3'd2;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_stall_req1", {31'd0, stall}, 32'd1);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_misalign", {31'd0, misalign}, 32'd0);
      req = 1'b0;
      @(negedge clk);
      chk("reset_stall_req0", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      monOn = 1'b1;

      // Initialise a 16-word window so every later load has a defined value.
      for (int i = 0; i < 16; i++) access(1'b1, 32'(i*4), $urandom, 3'd2, 1'b0);

      access(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 1'b0);
      access(1'b0, 32'h10, 32'd0, 3'd2, 1'b0);
      access(1'b1, 32'h11, 32'h00000080, 3'd0, 1'b0);
      access(1'b0, 32'h11, 32'd0, 3'd0, 1'b0);
      access(1'b0, 32'h11, 32'd0, 3'd4, 1'b0);
      access(1'b0, 32'h10, 32'd0, 3'd2, 1'b0);
      access(1'b1, 32'h12, 32'h00008001, 3'd1, 1'b0);
      access(1'b0, 32'h12, 32'd0, 3'd1, 1'b0);
      access(1'b0, 32'h12, 32'd0, 3'd5, 1'b0);
      access(1'b1, 32'h13, 32'h12345678, 3'd2, 1'b0);
      access(1'b0, 32'h10, 32'd0, 3'd2, 1'b0);
      access(1'b0, 32'h11, 32'd0, 3'd1, 1'b0);
      access(1'b1, 32'h400, 32'hA5A5A5A5, 3'd2, 1'b0);
      access(1'b0, 32'h0, 32'd0, 3'd2, 1'b0);
      access(1'b0, 32'h10, 32'd0, 3'd7, 1'b1);

      // Reset during WAIT abandons the store to 0x20.
      req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1; size = 3'd2;
      @(posedge clk); #1;
      reset = 1'b0; req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_stall", {31'd0, stall}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      access(1'b0, 32'h20, 32'd0, 3'd2, 1'b0);

      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         a = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63));
         access(1'($urandom), a, $urandom, 3'($urandom), 1'($urandom));
      end

      // LATENCY=0 instance: store then back-to-back loads with req held high.
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h11223344; size0 = 3'd2;
      @(negedge clk);
      chk("lat0_stall_accept", {31'd0, stall0}, 32'd1);
      chk("lat0_no_done_accept", {31'd0, done0}, 32'd0);
      @(posedge clk); #1;
      we0 = 1'b0; addr0 = 32'h42; size0 = 3'd5;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("lat0_done_pattern", {31'd0, done0}, 32'(k % 2 == 0));
         if (k > 0 && done0) chk("lat0_rdata", rdata0, 32'h00001122);
         @(posedge clk); #1;
      end
      req0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 32'(expQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in the data store; power of two.
REQ-002 Parameter LATENCY, default 2, wait cycles inserted between request acceptance and response; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req  input  1  MEM-stage access valid; held stable by the requester while stall=1.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 addr  input  32  byte address (ALU result from the MEM stage).
REQ-008 wdata  input  32  store data; lane 0 = bits 7:0.
REQ-009 size  input  3  funct3: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-010 rdata  output  32  extended load data; valid only while done=1.
REQ-011 stall  output  1  pipeline hold request.
REQ-012 done  output  1  one-cycle response pulse.
REQ-013 misalign  output  1  error flag; qualified by done.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-015 In IDLE with req=1, the block SHALL latch addr, we, wdata and size at the clock edge.
- Next state: WAIT if LATENCY>0, else RESP.
REQ-016 In WAIT, a wait counter SHALL advance by one per cycle.
- Next state: RESP after exactly LATENCY cycles in WAIT.
REQ-017 RESP SHALL last one cycle, then return unconditionally to IDLE.
REQ-018 stall SHALL be combinational:
- 1 when (state=IDLE and req=1) or state=WAIT;
- 0 in RESP and in IDLE with req=0.
REQ-019 done SHALL be 1 only in RESP.
REQ-020 Total request-to-done latency SHALL be LATENCY+1 cycles.
- A new req may be accepted in the first IDLE cycle after RESP.
REQ-021 Word index SHALL be addr[log2(DEPTH)+1:2].
- Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- addr[1:0] selects the byte or halfword lane; storage is little-endian.
REQ-022 Stores SHALL commit at the edge entering RESP.
- Byte store: writes lane addr[1:0] only.
- Half store: writes lanes addr[1]*2 and addr[1]*2+1.
- Word store: writes all four lanes.
- Unwritten lanes keep their value.
REQ-023 Loads SHALL present the selected lane(s) on rdata during RESP.
- Sizes 000 and 001: sign-extended.
- Sizes 100 and 101: zero-extended.
- Size 010: full word.
REQ-024 Size codes 011, 110 and 111 SHALL be treated as word accesses.
REQ-025 Misalignment is defined as either of:
- halfword access with addr[0]=1;
- word access with addr[1:0]!=00.
REQ-026 On a misaligned access:
- no store lane is written;
- rdata=0 and misalign=1 during RESP.
REQ-027 rdata and misalign SHALL be 0 whenever done=0.
REQ-028 Changes on req, addr, wdata or size during WAIT SHALL NOT affect the in-flight access.
- req dropping to 0 during WAIT does not cancel the access.
REQ-029 A store's data SHALL be visible to any load accepted after that store's RESP cycle.

Reset
REQ-030 While reset=0 at a clock edge:
- state becomes IDLE;
- wait counter clears to 0;
- done=0, misalign=0, rdata=0.
REQ-031 stall SHALL follow REQ-018 during reset, from state IDLE.
REQ-032 The data store SHALL NOT be cleared by reset.
REQ-033 Reset asserted during WAIT SHALL abandon the access without committing its store.
REQ-034 Reset asserted in the RESP cycle SHALL leave any store already committed in place.

Verification
REQ-035 LATENCY=2: sw addr=0x10 wdata=0xDEADBEEF, then lw addr=0x10.
- Each access: stall=1 for 3 cycles, done on the 3rd.
- Load: rdata=0xDEADBEEF, misalign=0.
REQ-036 After REQ-035, sb addr=0x11 wdata=0x00000080; then lb addr=0x11 and lbu addr=0x11.
- lb: rdata=0xFFFFFF80.
- lbu: rdata=0x00000080.
- lw addr=0x10: rdata=0xDEAD80EF.
REQ-037 sh addr=0x12 wdata=0x00008001, then lh and lhu at 0x12.
- lh: 0xFFFF8001.
- lhu: 0x00008001.
REQ-038 sw addr=0x13 wdata=0x12345678.
- done with misalign=1.
- A following lw 0x10 shows unchanged contents.
- lh at addr=0x11: misalign=1, rdata=0.
REQ-039 With DEPTH=256, sw addr=0x400 wdata=0xA5A5A5A5, then lw addr=0x0: rdata=0xA5A5A5A5 (wrap).
REQ-040 Reset disturbances:
- Reset pulsed during WAIT of sw 0x20 wdata=0x1: next cycle state IDLE, stall=0 with req=0; later lw 0x20 returns its pre-store value.
- LATENCY=0: back-to-back lw requests each produce done one cycle after acceptance.
